// File: rtl/pu_scheduler.sv
// Layer scheduler for a single 4-input PU: credit-gated index issue, latency tracking, result FIFO.
// Optional perf counters are enabled with `define PU_SCHED_PERF_EN.
module pu_scheduler #(
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned PU_LAT      = 4,
    parameter int unsigned FIFO_DEPTH  = PU_LAT + 1,
    parameter int unsigned IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pu_issue,
    output logic [IDX_W-1:0] pu_idx,
    input  logic [31:0]      pu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_idx
`ifdef PU_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_pass_cycles
`endif
);

    localparam int unsigned CNT_W = $clog2(NUM_NEURONS + 1);
    localparam int unsigned CRD_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   issue_cnt_q;
    logic [CNT_W-1:0]   acc_cnt_q;
    logic [CRD_W-1:0]   credit_q;
    logic [CRD_W-1:0]   credit_d;

    logic               pipe_vld_q [PU_LAT];
    logic [IDX_W-1:0]   pipe_idx_q [PU_LAT];

    logic [31:0]        fifo_data_q [FIFO_DEPTH];
    logic [IDX_W-1:0]   fifo_idx_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CRD_W-1:0]   count_q;
    logic [CRD_W-1:0]   count_d;

    logic               push;
    logic               pop;
    logic               issue;
    logic               fifo_full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push      = pipe_vld_q[PU_LAT-1];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign fifo_full = (count_q == CRD_W'(FIFO_DEPTH));

    // A same-cycle pop frees one credit, so issue is allowed even at full credit.
    assign issue = (state_q == StIssue) && ((credit_q < CRD_W'(FIFO_DEPTH)) || pop);

    assign pu_issue = issue;
    assign pu_idx   = issue_cnt_q[IDX_W-1:0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign out_data = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_idx  = out_valid ? fifo_idx_q[rd_ptr_q] : '0;

    always_comb begin
        credit_d = credit_q;
        unique case ({issue, pop})
            2'b10:   credit_d = credit_q + CRD_W'(1);
            2'b01:   credit_d = credit_q - CRD_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CRD_W'(1);
            2'b01:   count_d = count_q - CRD_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            issue_cnt_q <= '0;
            acc_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (issue) begin
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                acc_cnt_q <= acc_cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StIssue;
                        busy_q      <= 1'b1;
                        issue_cnt_q <= '0;
                        acc_cnt_q   <= '0;
                    end
                end
                StIssue: begin
                    if (issue && (issue_cnt_q == CNT_W'(NUM_NEURONS - 1))) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Leave on the final pop itself so done lands one cycle after it.
                    if (pop && (acc_cnt_q == CNT_W'(NUM_NEURONS - 1))) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    // Shadow of the PU pipeline: tail valid marks pu_result as belonging to the tail idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PU_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_idx_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= issue;
            pipe_idx_q[0] <= pu_idx;
            for (int i = 1; i < PU_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= pu_result;
            fifo_idx_q[wr_ptr_q]  <= pipe_idx_q[PU_LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

`ifdef PU_SCHED_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] pass_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            pass_q  <= '0;
        end else if ((state_q == StIdle) && start) begin
            stall_q <= '0;
            pass_q  <= '0;
        end else begin
            if ((state_q == StIssue) && !issue && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            // Counts ISSUE/DRAIN/DONE cycles: equals start-accept to done distance.
            if ((state_q != StIdle) && (pass_q != '1)) begin
                pass_q <= pass_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_pass_cycles  = pass_q;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));
    a_credit_max:  assert property (@(posedge clk) disable iff (!rst_n)
                                    credit_q <= CRD_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_pu_scheduler.sv
// Directed bench for pu_scheduler: throughput, backpressure, ignored start, async reset,
// random out_ready passes and (with PU_SCHED_PERF_EN) the perf counters.
module tb_pu_scheduler;

    localparam int NUM   = 8;
    localparam int LAT   = 4;
    localparam int DEPTH = 5;
    localparam int IW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          pu_issue;
    logic [IW-1:0] pu_idx;
    logic [31:0]   pu_result;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [IW-1:0] out_idx;
`ifdef PU_SCHED_PERF_EN
    logic [31:0]   perf_stall_cycles;
    logic [31:0]   perf_pass_cycles;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_idx, pop_cnt, issue_cnt, done_cnt;
    int start_cyc, done_cyc, last_pop_cyc;

    pu_scheduler #(
        .NUM_NEURONS(NUM),
        .PU_LAT(LAT),
        .FIFO_DEPTH(DEPTH),
        .IDX_W(IW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .pu_issue(pu_issue),
        .pu_idx(pu_idx),
        .pu_result(pu_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_idx(out_idx)
`ifdef PU_SCHED_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_pass_cycles(perf_pass_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed FP32 encodings of idx * 1.0f.
    function automatic logic [31:0] fp_of(input int i);
        case (i)
            0:       return 32'h0000_0000;
            1:       return 32'h3F80_0000;
            2:       return 32'h4000_0000;
            3:       return 32'h4040_0000;
            4:       return 32'h4080_0000;
            5:       return 32'h40A0_0000;
            6:       return 32'h40C0_0000;
            7:       return 32'h40E0_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // PU model: fixed-latency pipeline, garbage when no operation was issued.
    logic [31:0] pu_pipe [LAT];
    always @(posedge clk) begin
        pu_pipe[0] <= pu_issue ? fp_of(int'(pu_idx)) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) pu_pipe[i] <= pu_pipe[i-1];
    end
    assign pu_result = pu_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard and event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pu_issue) issue_cnt++;
            if (out_valid && out_ready) begin
                check("order_idx", 32'(out_idx), 32'(exp_idx % NUM));
                check("order_data", out_data, fp_of(exp_idx));
                exp_idx++;
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // hold < 0: ready always high; hold >= 0: ready low for cycles 0..hold after start.
    task automatic do_pass(input int hold, input bit rnd, input int s1, input int s2,
                           input int probe);
        int k;
        exp_idx = 0; pop_cnt = 0; issue_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : (hold < 0);
        k = 0;
        while (done_cnt == 0 && k < 400) begin
            @(posedge clk); #1;
            k++;
            start = (k == s1 || k == s2);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : (k > hold);
            if (k == probe) begin
                check("bp_issue_cnt", 32'(issue_cnt), 32'(DEPTH));
                check("bp_issue_low", 32'(pu_issue), 32'd0);
                check("bp_busy", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        check("pass_pops", 32'(pop_cnt), 32'(NUM));
        check("pass_issues", 32'(issue_cnt), 32'(NUM));
        check("pass_done_cnt", 32'(done_cnt), 32'd1);
        check("done_after_pop", 32'(done_cyc), 32'(last_pop_cyc + 1));
        if (hold < 0 && !rnd) check("done_latency", 32'(done_cyc - start_cyc), 32'(1 + NUM + LAT + 1));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        exp_idx = 0; pop_cnt = 0; issue_cnt = 0; done_cnt = 0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_issue", 32'(pu_issue), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_pass(-1, 1'b0, -1, -1, -1);          // basic, back-to-back
        do_pass(20, 1'b0, -1, -1, 20);          // backpressure from start
        do_pass(-1, 1'b0, 3, 11, -1);           // start pulsed mid-ISSUE and mid-DRAIN
        repeat (5) @(posedge clk);
        #1;
        check("ign_start_busy", 32'(busy), 32'd0);
        check("ign_start_issues", 32'(issue_cnt), 32'(NUM));
        check("ign_start_dones", 32'(done_cnt), 32'd1);

        // Reset with 2 results in the FIFO and 3 still in the PU pipeline.
        exp_idx = 0; pop_cnt = 0; issue_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_issues", 32'(issue_cnt), 32'(DEPTH));
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_issue", 32'(pu_issue), 32'd0);
        check("arst_idx", 32'(pu_idx), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", out_data, 32'd0);
        check("arst_oidx", 32'(out_idx), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("no_stale_pops", 32'(pop_cnt), 32'd0);
        check("no_stale_valid", 32'(out_valid), 32'd0);
        do_pass(-1, 1'b0, -1, -1, -1);          // fresh pass after reset

        do_pass(10, 1'b0, -1, -1, -1);          // ready low for 10 cycles after start
`ifdef PU_SCHED_PERF_EN
        check("perf_stall", perf_stall_cycles, 32'd5);
        check("perf_pass", perf_pass_cycles, 32'(done_cyc - start_cyc));
`endif

        for (int p = 0; p < 1000; p++) do_pass(-1, 1'b1, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pu_scheduler.md
Name: pu_scheduler

Overview:
- Sequences one 4-input processing unit (4 FP32 multipliers, adder tree, activation; fixed pipeline latency, no stall input) across a layer of NUM_NEURONS neurons.
- On start, issues neuron indices 0..NUM_NEURONS-1, one per cycle when credit allows.
  - The index drives external weight/activation muxes into the PU.
- Tags each result as it leaves the PU pipeline and buffers it in a small FIFO.
- Presents results on a valid/ready stream; credit-based issue keeps results from being lost under backpressure.

Parameters:
- NUM_NEURONS, 8, neurons per layer pass (>=1).
- PU_LAT, 4, cycles from pu_issue high to the matching result on pu_result (>=1).
- FIFO_DEPTH, PU_LAT+1, result FIFO entries (>=PU_LAT+1).
- IDX_W, $clog2(NUM_NEURONS) (min 1), width of neuron index.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a layer pass; accepted only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse when the last result has been accepted downstream
- pu_issue  out  1  PU operands valid this cycle (mux select below is live)
- pu_idx  out  IDX_W  neuron index whose operands are presented to the PU
- pu_result  in  32  PU output (activation output, FP32)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts the head
- out_data  out  32  result value at FIFO head
- out_idx  out  IDX_W  neuron index of FIFO head

Behaviour:
- Reset (rst_n low, any time including mid-pass):
  - All outputs go to 0: busy, done, pu_issue, pu_idx, out_valid, out_data, out_idx.
  - FSM goes to IDLE; FIFO is emptied; in-flight tracking is cleared.
  - Results still in the PU pipeline are discarded.
- FSM states:
  - IDLE: start=1 goes to ISSUE, clears issue count and accepted count.
  - ISSUE: pu_issue=1 in any cycle where credit < FIFO_DEPTH. After the issue of index NUM_NEURONS-1, go to DRAIN.
  - DRAIN: no issue. Once accepted count = NUM_NEURONS, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - start seen outside IDLE is ignored.
- Credit and issue:
  - credit = in-flight count + FIFO occupancy.
  - An issue increments credit; a downstream pop (out_valid & out_ready) decrements it. Both in one cycle leaves credit unchanged.
  - An issue may use the credit freed by a same-cycle pop.
- Pipeline tracking:
  - PU_LAT-deep shift register carries (valid, idx).
  - Stage 0 loads (pu_issue, pu_idx). Tail valid marks pu_result as belonging to the tail idx in that cycle.
  - That cycle, {pu_result, tail idx} is pushed into the FIFO. The credit scheme guarantees the FIFO is never full on a push; overflow is a design error and is asserted in simulation.
- FIFO:
  - First-word fall-through: out_data/out_idx are valid combinationally from the head whenever out_valid=1.
  - Simultaneous push and pop is allowed at any occupancy, including empty.
  - Empty case: the pushed entry appears on the next cycle, never the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order is strictly issue order (idx 0,1,2,...).
- Throughput: with out_ready held high, one issue per cycle. The last result is accepted at start-accept + 1 + NUM_NEURONS + PU_LAT cycles (±0, checked). done rises the cycle after that.
- A new pass may start the cycle after done.

Optional Feature:
- Macro: PU_SCHED_PERF_EN.
- When defined:
  - Adds output perf_stall_cycles (32 bits): counts cycles in ISSUE where issue is blocked by credit.
  - Adds output perf_pass_cycles (32 bits): cycles from start accept to done.
  - Both clear on start accept and saturate at all-ones.
  - rst_n clears both to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic pass, NUM_NEURONS=8, PU_LAT=4, out_ready=1, model PU returns idx*1.0f:
  - Expected stream: out_idx 0..7 with data 0x00000000, 0x3F800000, ... 0x40E00000.
  - Back-to-back issue across 8 cycles; done exactly 1+8+4+1 cycles after start.
- Backpressure: out_ready=0 from start.
  - Exactly FIFO_DEPTH=5 issues occur, then pu_issue stays 0.
  - Releasing out_ready drains in order 0..7 with no loss or duplicate; done follows the 8th pop.
- Random out_ready (50%, 1000 passes):
  - Scoreboard order and values hold.
  - Assertion: FIFO never overflows; credit never exceeds 5.
- start pulsed while busy (mid-ISSUE and mid-DRAIN): ignored; pass completes normally with exactly 8 results and one done.
- rst_n low while 3 results are in flight and 2 are in the FIFO:
  - All outputs go to 0 immediately (asynchronous).
  - After release, no stale results appear; a fresh start yields idx 0..7 correctly.
- PU_SCHED_PERF_EN defined, out_ready=0 for 10 cycles after start:
  - perf_stall_cycles = 5.
  - perf_pass_cycles matches the bench-measured start-to-done count.
